tc_pl_cap_gain_agc: RTL and testbench
=====================================

Name: tc_pl_cap_gain_agc

Overview:
- Automatic gain-level controller that sits directly upstream of the cap-gain SPI programming block.
- Measures the peak magnitude of the capture ADC stream over a programmable window.
- Picks a low/mid/high gain level and issues a gain-set request (gset_en + gset_lmh code), then waits for gset_lmh_cmpt.
- Holds off measurement for a settle time so new gain transients are not measured.

Parameters:
- CAP0_13, 6, width of the gain code sent downstream.
- ADC_W, 16, ADC sample width (signed two's complement).
- WIN_W, 16, width of the window-length input.
- SET_W, 16, width of the settle-length input.
- TO_W, 20, completion-timeout counter width; timeout = 2^TO_W cycles.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; active-low, asynchronous.
- agc_en, in, 1, level; enables the controller.
- win_len, in, WIN_W, valid samples per window; 0 is treated as 1.
- settle_len, in, SET_W, settle cycles after completion; 0 = no settle.
- thr_hi, in, ADC_W-1, peak above this reduces gain.
- thr_lo, in, ADC_W-1, peak below this increases gain.
- code_l / code_m / code_h, in, CAP0_13 each, codes for levels 0 / 1 / 2 (2 = highest gain).
- adc_valid, in, 1, sample strobe.
- adc_data, in, ADC_W, signed sample.
- gset_en, out, 1, one-cycle request pulse to the gain-SPI block.
- gset_lmh, out, CAP0_13, gain code; stable from the gset_en pulse until completion.
- gset_lmh_cmpt, in, 1, completion from the gain-SPI block; a single high cycle is sufficient.
- gain_lvl, out, 2, currently applied level.
- gain_lock, out, 1, high when the last window produced no change.
- peak_out, out, ADC_W-1, peak of the last completed window.
- agc_busy, out, 1, high in any state other than IDLE.
- agc_err, out, 1, sticky completion-timeout flag; cleared only by rst.

Behaviour:

Reset values:
- gset_en = 0, gset_lmh = 0, gain_lvl = 1, gain_lock = 0, peak_out = 0, agc_busy = 0, agc_err = 0.
- FSM enters IDLE; all counters are cleared.

Magnitude:
- abs(adc_data), saturated: -2^(ADC_W-1) maps to 2^(ADC_W-1)-1.
- Result is ADC_W-1 bits, registered with 1 cycle latency.

FSM states: IDLE, INIT, MEAS, DECIDE, SET, WAIT_CMPT, SETTLE.
- IDLE: when agc_en = 1, go to INIT.
- INIT: next level = 1 (mid); go to SET. This always programs a known gain on enable.
- MEAS:
  - Clear peak and sample counter on entry.
  - Each adc_valid cycle: peak = max(peak, mag) and the counter increments.
  - After max(win_len, 1) samples, latch peak_out and go to DECIDE.
  - If agc_en = 0, go to IDLE and discard the partial window.
- DECIDE (1 cycle):
  - peak > thr_hi and gain_lvl > 0: next = gain_lvl - 1, go to SET.
  - Else peak < thr_lo and gain_lvl < 2: next = gain_lvl + 1, go to SET.
  - Else: gain_lock = 1, return to MEAS.
  - Saturated at the rails: a high peak at level 0 or a low peak at level 2 gives gain_lock = 1.
  - thr_hi takes priority when both conditions hold.
- SET (1 cycle):
  - gset_en = 1; gset_lmh = code for next level; gain_lock = 0.
  - Clear the timeout counter; go to WAIT_CMPT.
- WAIT_CMPT:
  - On gset_lmh_cmpt = 1: gain_lvl = next, go to SETTLE.
  - If the timeout counter saturates: agc_err = 1, go to IDLE; gain_lvl is unchanged.
  - agc_en = 0 is ignored here; the in-flight SPI transfer always finishes.
  - A gset_lmh_cmpt arriving in any other state is ignored.
- SETTLE:
  - Count settle_len cycles while ignoring adc_valid, then go to MEAS; settle_len = 0 goes straight to MEAS.
  - If agc_en = 0, go to IDLE.

General:
- gset_en never asserts twice without an intervening completion or timeout.
- Window length, settle length, thresholds and codes are sampled at the start of each window or settle period; changing them mid-window has no effect until the next one.
- rst asserted mid-operation, including in WAIT_CMPT, forces reset values immediately.

Test Plan:
- Release rst with agc_en = 1, code_m = 6'h15 -> single gset_en pulse with gset_lmh = 6'h15. Pulse cmpt 40 cycles later -> gain_lvl = 1, then MEAS.
- Level 1, win_len = 4, samples {0x1000, 0x7000, 0x0100, 0x2000}, thr_hi = 0x6000 -> peak_out = 0x7000 and gset_lmh = code_l. After cmpt, no samples are counted for settle_len = 10 cycles.
- Window containing adc_data = 0x8000 -> peak_out = 0x7FFF (saturated). Window with peak 0x0010 < thr_lo = 0x0100 at level 2 -> no gset_en, gain_lock = 1.
- win_len = 0 -> each single valid sample completes a window; adc_valid gaps do not advance the counter.
- Withhold cmpt for 2^TO_W cycles -> agc_err = 1, FSM in IDLE, gain_lvl unchanged. agc_err stays 1 until rst.
- Drop agc_en during WAIT_CMPT -> cmpt is still accepted, then IDLE. Assert rst during WAIT_CMPT -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/tc_pl_cap_gain_agc.sv
// tc_pl_cap_gain_agc
// Automatic gain-level controller placed in front of the cap-gain SPI block.
// It measures the peak magnitude of the capture ADC stream over a window and
// moves between three gain levels (0 = low, 1 = mid, 2 = high gain). Each
// change is issued as a one-cycle gset_en pulse with the matching gset_lmh
// code, and the controller then waits for gset_lmh_cmpt. After a completion
// it waits for a settle period so that the new gain's transient is not
// measured.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   agc_en              enables the controller (level)
//   win_len             valid samples per window (0 behaves as 1)
//   settle_len          settle cycles after each completion (0 = none)
//   thr_hi / thr_lo     a peak above thr_hi lowers gain, a peak below thr_lo raises it
//   code_l/_m/_h        gain codes for levels 0 / 1 / 2
//   adc_valid/adc_data  signed capture sample stream
//   gset_en/gset_lmh    gain-set request pulse and gain code to the SPI block
//   gset_lmh_cmpt       completion strobe from the SPI block
//   gain_lvl            level currently applied
//   gain_lock           last window requested no change
//   peak_out            peak of the last completed window
//   agc_busy            controller is not idle
//   agc_err             sticky completion-timeout flag
module tc_pl_cap_gain_agc #(
  parameter int CAP0_13 = 6,
  parameter int ADC_W   = 16,
  parameter int WIN_W   = 16,
  parameter int SET_W   = 16,
  parameter int TO_W    = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    agc_en,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [SET_W-1:0]        settle_len,
  input  logic [ADC_W-2:0]        thr_hi,
  input  logic [ADC_W-2:0]        thr_lo,
  input  logic [CAP0_13-1:0]      code_l,
  input  logic [CAP0_13-1:0]      code_m,
  input  logic [CAP0_13-1:0]      code_h,
  input  logic                    adc_valid,
  input  logic signed [ADC_W-1:0] adc_data,
  output logic                    gset_en,
  output logic [CAP0_13-1:0]      gset_lmh,
  input  logic                    gset_lmh_cmpt,
  output logic [1:0]              gain_lvl,
  output logic                    gain_lock,
  output logic [ADC_W-2:0]        peak_out,
  output logic                    agc_busy,
  output logic                    agc_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MEAS, S_DECIDE, S_SET, S_WAIT, S_SETTLE
  } state_t;

  state_t state_q, state_d;

  logic [ADC_W-2:0]   mag_p1;
  logic               vld_p1;
  logic [ADC_W-2:0]   peak_q, peak_out_q, peak_nxt;
  logic [WIN_W-1:0]   cnt_q, win_q, win_eff;
  logic [WIN_W:0]     cnt_inc;
  logic [SET_W-1:0]   set_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [ADC_W-2:0]   thr_hi_q, thr_lo_q;
  logic [CAP0_13-1:0] code_l_q, code_m_q, code_h_q, gset_lmh_q, tgt_code;
  logic [1:0]         lvl_q, nxt_lvl_q, tgt_lvl;
  logic               lock_q, err_q;
  logic               win_done, go_dn, go_up, to_sat;
  logic               meas_entry, cfg_load, set_entry;

  // Saturating absolute value: the most negative code has no positive twin.
  function automatic logic [ADC_W-2:0] sat_abs(input logic signed [ADC_W-1:0] x);
    logic signed [ADC_W-1:0] neg;
    if (x == {1'b1, {(ADC_W-1){1'b0}}}) return {(ADC_W-1){1'b1}};
    neg = -x;
    return x[ADC_W-1] ? neg[ADC_W-2:0] : x[ADC_W-2:0];
  endfunction

  // Stage p1: registered magnitude; only samples seen while measuring are marked valid
  always_ff @(posedge clk) begin
    mag_p1 <= sat_abs(adc_data);
  end

  assign win_eff  = (win_q == '0) ? WIN_W'(1) : win_q;
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign win_done = vld_p1 && (cnt_inc >= {1'b0, win_eff});
  assign peak_nxt = (mag_p1 > peak_q) ? mag_p1 : peak_q;
  assign to_sat   = &to_cnt_q;

  // A high peak wins over a low peak; at the rails the request collapses to a lock.
  assign go_dn = (peak_out_q > thr_hi_q) && (lvl_q != 2'd0);
  assign go_up = !(peak_out_q > thr_hi_q) && (peak_out_q < thr_lo_q) && (lvl_q != 2'd2);

  always_comb begin
    tgt_lvl = lvl_q + 2'd1;
    if (state_q == S_INIT) tgt_lvl = 2'd1;
    else if (go_dn)        tgt_lvl = lvl_q - 2'd1;
  end

  always_comb begin
    tgt_code = code_m_q;
    if (tgt_lvl == 2'd0)      tgt_code = code_l_q;
    else if (tgt_lvl == 2'd2) tgt_code = code_h_q;
  end

  assign meas_entry = (state_d == S_MEAS) && (state_q != S_MEAS);
  assign set_entry  = (state_d == S_SET) && (state_q != S_SET);
  assign cfg_load   = meas_entry || ((state_q == S_IDLE) && (state_d == S_INIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (agc_en) state_d = S_INIT;
      S_INIT:   state_d = S_SET;
      S_MEAS:   if (!agc_en) state_d = S_IDLE;
                else if (win_done) state_d = S_DECIDE;
      S_DECIDE: state_d = (go_dn || go_up) ? S_SET : S_MEAS;
      S_SET:    state_d = S_WAIT;
      // agc_en is deliberately not looked at: the SPI transfer must finish.
      S_WAIT:   if (gset_lmh_cmpt) state_d = (settle_len == '0) ? S_MEAS : S_SETTLE;
                else if (to_sat) state_d = S_IDLE;
      S_SETTLE: if (!agc_en) state_d = S_IDLE;
                else if (set_cnt_q == SET_W'(1)) state_d = S_MEAS;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gset_en   = (state_q == S_SET);
    agc_busy  = (state_q != S_IDLE);
    gset_lmh  = gset_lmh_q;
    gain_lvl  = lvl_q;
    gain_lock = lock_q;
    peak_out  = peak_out_q;
    agc_err   = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      peak_q     <= '0;
      peak_out_q <= '0;
      cnt_q      <= '0;
      win_q      <= '0;
      set_cnt_q  <= '0;
      to_cnt_q   <= '0;
      thr_hi_q   <= '0;
      thr_lo_q   <= '0;
      code_l_q   <= '0;
      code_m_q   <= '0;
      code_h_q   <= '0;
      gset_lmh_q <= '0;
      lvl_q      <= 2'd1;
      nxt_lvl_q  <= 2'd1;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vld_p1 <= adc_valid && (state_q == S_MEAS);

      // Configuration is snapshotted so mid-window edits wait for the next window.
      if (cfg_load) begin
        win_q    <= win_len;
        thr_hi_q <= thr_hi;
        thr_lo_q <= thr_lo;
        code_l_q <= code_l;
        code_m_q <= code_m;
        code_h_q <= code_h;
      end

      if (meas_entry) begin
        peak_q <= '0;
        cnt_q  <= '0;
      end else if ((state_q == S_MEAS) && vld_p1) begin
        peak_q <= peak_nxt;
        cnt_q  <= cnt_q + 1'b1;
        if (win_done) peak_out_q <= peak_nxt;
      end

      if (set_entry) begin
        nxt_lvl_q  <= tgt_lvl;
        gset_lmh_q <= tgt_code;
        lock_q     <= 1'b0;
      end else if ((state_q == S_DECIDE) && (state_d == S_MEAS)) begin
        lock_q <= 1'b1;
      end

      if (state_q == S_SET)                 to_cnt_q <= '0;
      else if ((state_q == S_WAIT) && !to_sat) to_cnt_q <= to_cnt_q + 1'b1;

      if (state_q == S_WAIT) begin
        if (gset_lmh_cmpt) lvl_q <= nxt_lvl_q;
        else if (to_sat)   err_q <= 1'b1;
      end

      if ((state_q == S_WAIT) && (state_d == S_SETTLE)) set_cnt_q <= settle_len;
      else if (state_q == S_SETTLE)                     set_cnt_q <= set_cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_gain_agc.sv
module tb_tc_pl_cap_gain_agc;
  localparam int CAP0_13 = 6;
  localparam int ADC_W   = 16;
  localparam int WIN_W   = 16;
  localparam int SET_W   = 16;
  localparam int TO_W    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    agc_en;
  logic [WIN_W-1:0]        win_len;
  logic [SET_W-1:0]        settle_len;
  logic [ADC_W-2:0]        thr_hi, thr_lo;
  logic [CAP0_13-1:0]      code_l, code_m, code_h;
  logic                    adc_valid;
  logic signed [ADC_W-1:0] adc_data;
  logic                    gset_en;
  logic [CAP0_13-1:0]      gset_lmh;
  logic                    gset_lmh_cmpt;
  logic [1:0]              gain_lvl;
  logic                    gain_lock;
  logic [ADC_W-2:0]        peak_out;
  logic                    agc_busy;
  logic                    agc_err;

  tc_pl_cap_gain_agc #(
    .CAP0_13(CAP0_13), .ADC_W(ADC_W), .WIN_W(WIN_W), .SET_W(SET_W), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .agc_en(agc_en), .win_len(win_len),
    .settle_len(settle_len), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .code_l(code_l), .code_m(code_m), .code_h(code_h),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .gset_en(gset_en), .gset_lmh(gset_lmh), .gset_lmh_cmpt(gset_lmh_cmpt),
    .gain_lvl(gain_lvl), .gain_lock(gain_lock), .peak_out(peak_out),
    .agc_busy(agc_busy), .agc_err(agc_err)
  );

  int ncmp = 0;
  int nfail = 0;
  int gset_cnt = 0;

  always @(negedge clk) if (gset_en === 1'b1) gset_cnt++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [15:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
    adc_data  = '0;
  endtask

  task automatic wait_gset(input string tag, input int max);
    int k = 0;
    while (gset_en !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, gset_en}, 32'd1);
  endtask

  task automatic cmpt();
    tick(2);
    gset_lmh_cmpt = 1'b1;
    tick();
    gset_lmh_cmpt = 1'b0;
  endtask

  initial begin
    rst = 1'b0; agc_en = 1'b1; win_len = 16'd4; settle_len = '0;
    thr_hi = 15'h6000; thr_lo = 15'h0100;
    code_l = 6'h0A; code_m = 6'h15; code_h = 6'h2A;
    adc_valid = 1'b0; adc_data = '0; gset_lmh_cmpt = 1'b0;
    tick(2);
    chk("rst_gset_en",   {31'd0, gset_en},   32'd0);
    chk("rst_gset_lmh",  {26'd0, gset_lmh},  32'd0);
    chk("rst_gain_lvl",  {30'd0, gain_lvl},  32'd1);
    chk("rst_gain_lock", {31'd0, gain_lock}, 32'd0);
    chk("rst_peak_out",  {17'd0, peak_out},  32'd0);
    chk("rst_busy",      {31'd0, agc_busy},  32'd0);
    chk("rst_err",       {31'd0, agc_err},   32'd0);
    rst = 1'b1;

    // Enable programs mid gain once
    wait_gset("init_gset", 10);
    chk("init_code", {26'd0, gset_lmh}, 32'h15);
    tick(40);
    chk("init_single_pulse", gset_cnt, 1);
    cmpt();
    chk("init_lvl",  {30'd0, gain_lvl}, 32'd1);
    chk("init_busy", {31'd0, agc_busy}, 32'd1);

    // High peak at mid, samples with gaps in between
    smp(16'h1000); tick(); smp(16'h7000); smp(16'h0100); tick(2); smp(16'h2000);
    wait_gset("dn_gset", 10);
    chk("dn_peak", {17'd0, peak_out}, 32'h7000);
    chk("dn_code", {26'd0, gset_lmh}, 32'h0A);
    chk("dn_lvl_before_cmpt", {30'd0, gain_lvl}, 32'd1);
    settle_len = 16'd10;
    cmpt();
    chk("dn_lvl", {30'd0, gain_lvl}, 32'd0);
    // Large samples during settle must be ignored
    adc_valid = 1'b1; adc_data = 16'h7FFF;
    tick(10);
    adc_valid = 1'b0; adc_data = '0;
    repeat (4) smp(16'h0200);
    tick(4);
    chk("settle_peak", {17'd0, peak_out},  32'h0200);
    chk("settle_lock", {31'd0, gain_lock}, 32'd1);
    chk("settle_nogset", gset_cnt, 2);

    // Most negative sample saturates; high peak at level 0 locks
    smp(16'h8000); repeat (3) smp(16'h0010);
    tick(4);
    chk("sat_peak", {17'd0, peak_out},  32'h7FFF);
    chk("sat_lock", {31'd0, gain_lock}, 32'd1);
    chk("sat_lvl",  {30'd0, gain_lvl},  32'd0);
    chk("sat_nogset", gset_cnt, 2);
    smp(16'hEDCC); repeat (3) smp(16'h0100);
    tick(4);
    chk("neg_peak", {17'd0, peak_out}, 32'h1234);

    // Low peaks climb to level 2
    settle_len = '0;
    smp(16'h0010); smp(16'hFFF8); smp(16'h0004); smp(16'h0000);
    wait_gset("up1_gset", 10);
    chk("up1_code", {26'd0, gset_lmh},  32'h15);
    chk("up1_lock", {31'd0, gain_lock}, 32'd0);
    cmpt();
    chk("up1_lvl", {30'd0, gain_lvl}, 32'd1);
    repeat (4) smp(16'h0010);
    wait_gset("up2_gset", 10);
    chk("up2_code", {26'd0, gset_lmh}, 32'h2A);
    cmpt();
    chk("up2_lvl", {30'd0, gain_lvl}, 32'd2);
    repeat (4) smp(16'h0010);
    tick(4);
    chk("rail_lock", {31'd0, gain_lock}, 32'd1);
    chk("rail_peak", {17'd0, peak_out},  32'h0010);
    chk("rail_lvl",  {30'd0, gain_lvl},  32'd2);
    chk("rail_nogset", gset_cnt, 4);

    // win_len change waits for the next window, then 0 acts as 1
    win_len = '0;
    smp(16'h3000);
    tick(4);
    chk("win_latched", {17'd0, peak_out}, 32'h0010);
    repeat (3) smp(16'h0010);
    tick(4);
    chk("win_old_done", {17'd0, peak_out}, 32'h3000);
    smp(16'h0020);
    tick(4);
    chk("win0_a", {17'd0, peak_out}, 32'h0020);
    smp(16'h0030);
    tick(4);
    chk("win0_b", {17'd0, peak_out}, 32'h0030);

    // Completion timeout
    smp(16'h7000);
    wait_gset("to_gset", 10);
    chk("to_code", {26'd0, gset_lmh}, 32'h15);
    agc_en = 1'b0;
    for (int k = 0; k < 400 && agc_busy !== 1'b0; k++) tick();
    chk("to_idle", {31'd0, agc_busy}, 32'd0);
    chk("to_err",  {31'd0, agc_err},  32'd1);
    chk("to_lvl",  {30'd0, gain_lvl}, 32'd2);
    chk("to_pulses", gset_cnt, 5);
    tick(5);
    chk("err_sticky", {31'd0, agc_err}, 32'd1);

    // agc_en dropped during WAIT: completion still accepted
    agc_en = 1'b1;
    wait_gset("drop_gset", 10);
    chk("drop_code", {26'd0, gset_lmh}, 32'h15);
    agc_en = 1'b0;
    cmpt();
    chk("drop_lvl",  {30'd0, gain_lvl}, 32'd1);
    tick();
    chk("drop_idle", {31'd0, agc_busy}, 32'd0);
    chk("drop_err",  {31'd0, agc_err},  32'd1);

    // Reset during WAIT
    agc_en = 1'b1;
    smp(16'h0000);
    wait_gset("rstw_gset", 10);
    tick(2);
    chk("rstw_busy_before", {31'd0, agc_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstw_gset_en",  {31'd0, gset_en},   32'd0);
    chk("rstw_gset_lmh", {26'd0, gset_lmh},  32'd0);
    chk("rstw_lvl",      {30'd0, gain_lvl},  32'd1);
    chk("rstw_lock",     {31'd0, gain_lock}, 32'd0);
    chk("rstw_peak",     {17'd0, peak_out},  32'd0);
    chk("rstw_busy",     {31'd0, agc_busy},  32'd0);
    chk("rstw_err",      {31'd0, agc_err},   32'd0);
    agc_en = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
